bam_seq: RTL and testbench

Sequenced, parametrised register-bank / ALU / data-memory datapath and the next generation of the combinational bank-ALU-memory path. A command on `start` reads two registers, executes one of eight ALU operations, optionally stores the result in data memory and writes it back to the register bank, then returns the memory word with a one-cycle `done` pulse. It is the execute/memory slice of the processor datapath, sequenced by a 5-state FSM with a start/busy/done handshake and a load port for register initialisation.

---
 rtl/bam_seq.sv | 155 +++++++++++++++
 tb/tb_bam_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bam_seq.sv
// bam_seq: sequenced register-bank / ALU / data-memory slice with a start/busy/done handshake.
// Optional register write-back is built when BAM_SEQ_WB_EN is defined.
module bam_seq #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter int MEM_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic [REG_AW-1:0] wa,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_we,
  input  logic              wb,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  output logic              busy,
  output logic              done,
  output logic              zf,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  dout
);

  localparam int NREG = 1 << REG_AW;
  localparam int NMEM = 1 << MEM_AW;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;

  state_t                   state;
  logic                     vld_p0;
  logic [WIDTH-1:0]         regBank [NREG];
  logic [WIDTH-1:0]         memBank [NMEM];

  logic [2:0]               cmdOp;
  logic [REG_AW-1:0]        cmdRa1;
  logic [REG_AW-1:0]        cmdRa2;
  logic [REG_AW-1:0]        cmdWa;
  logic [MEM_AW-1:0]        cmdMemAddr;
  logic                     cmdMemWe;
  logic signed [WIDTH-1:0]  opA_p1;
  logic signed [WIDTH-1:0]  opB_p1;
  logic [WIDTH-1:0]         aluRes_p1;
  logic                     accept;

`ifdef BAM_SEQ_WB_EN
  logic                     cmdWb;
`else
  logic                     unusedWb;
  assign unusedWb = wb;
`endif

  function automatic logic [WIDTH-1:0] aluOp(input logic [2:0] sel,
                                             input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (sel)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b011:  r = a - b;
      3'b100:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      3'b101:  r = ~(a | b);
      3'b110:  r = a ^ b;
      default: r = a;
    endcase
    return r;
  endfunction

  assign aluRes_p1 = aluOp(cmdOp, opA_p1, opB_p1);

  // A command is captured one edge before READ; the DONE cycle may capture the next one.
  assign accept = start && !vld_p0 && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vld_p0     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      zf         <= 1'b0;
      result     <= '0;
      dout       <= '0;
      cmdOp      <= '0;
      cmdRa1     <= '0;
      cmdRa2     <= '0;
      cmdWa      <= '0;
      cmdMemAddr <= '0;
      cmdMemWe   <= 1'b0;
`ifdef BAM_SEQ_WB_EN
      cmdWb      <= 1'b0;
`endif
      opA_p1     <= '0;
      opB_p1     <= '0;
      for (int i = 0; i < NREG; i++) regBank[i] <= '0;
      for (int i = 0; i < NMEM; i++) memBank[i] <= '0;
    end else begin
      done <= 1'b0;
      // p0: command capture
      if (accept) begin
        cmdOp      <= op;
        cmdRa1     <= ra1;
        cmdRa2     <= ra2;
        cmdWa      <= wa;
        cmdMemAddr <= mem_addr;
        cmdMemWe   <= mem_we;
`ifdef BAM_SEQ_WB_EN
        cmdWb      <= wb;
`endif
        vld_p0     <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (ld_en) regBank[ld_addr] <= ld_data;
          if (vld_p0) begin
            vld_p0 <= 1'b0;
            busy   <= 1'b1;
            state  <= READ;
          end
        end
        // p1: operand latch
        READ: begin
          opA_p1 <= regBank[cmdRa1];
          opB_p1 <= regBank[cmdRa2];
          state  <= EXEC;
        end
        // p2: execute
        EXEC: begin
          result <= aluRes_p1;
          zf     <= (aluRes_p1 == '0);
          state  <= WRITE;
        end
        // p3: store, write-back and memory read with forwarding of the word just stored
        WRITE: begin
          if (cmdMemWe) memBank[cmdMemAddr] <= result;
`ifdef BAM_SEQ_WB_EN
          if (cmdWb) regBank[cmdWa] <= result;
`endif
          dout  <= cmdMemWe ? result : memBank[cmdMemAddr];
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bam_seq.sv
// Directed testbench for bam_seq: ALU ops, memory store/readback, handshake and reset abort.
module tb_bam_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, ld_addr = '0;
  logic [4:0]  mem_addr = '0;
  logic        mem_we = 1'b0, wb = 1'b0, ld_en = 1'b0;
  logic [31:0] ld_data = '0;
  logic        busy, done, zf;
  logic [31:0] result, dout;

  int errors = 0;
  int checks = 0;
  int doneCnt = 0;
  int lat;
  int base;
  logic busyAt1;
  logic [31:0] expWb;

  bam_seq #(.WIDTH(32), .REG_AW(5), .MEM_AW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .ra1(ra1), .ra2(ra2), .wa(wa),
    .mem_addr(mem_addr), .mem_we(mem_we), .wb(wb), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .busy(busy), .done(done), .zf(zf), .result(result), .dout(dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) doneCnt <= doneCnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Issues a command (optionally with a same-cycle load) and waits up to 20 cycles for done.
  task automatic runCmd(input logic [2:0] o, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] w, input logic [4:0] ma, input logic we,
                        input logic wbb, input logic le, input logic [4:0] la,
                        input logic [31:0] ld);
    @(negedge clk);
    op = o; ra1 = a1; ra2 = a2; wa = w; mem_addr = ma; mem_we = we; wb = wbb;
    ld_en = le; ld_addr = la; ld_data = ld;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ld_en = 1'b0;
    lat = 0; busyAt1 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) busyAt1 = busy;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
`ifdef BAM_SEQ_WB_EN
    expWb = 32'h0000_000F;
`else
    expWb = 32'h0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_zf", {31'b0, zf}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_dout", dout, 32'd0);

    // ADD with store
    load(5'd1, 32'd5);
    load(5'd2, 32'd3);
    runCmd(3'b010, 5'd1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("add_latency", lat, 32'd4);
    check("add_busy1", {31'b0, busyAt1}, 32'd1);
    check("add_result", result, 32'd8);
    check("add_zf", {31'b0, zf}, 32'd0);
    check("add_dout", dout, 32'd8);
    @(negedge clk);
    check("done_pulse", {31'b0, done}, 32'd0);
    check("busy_after", {31'b0, busy}, 32'd0);

    // SUB to zero
    load(5'd1, 32'd9);
    load(5'd2, 32'd9);
    runCmd(3'b011, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("sub_result", result, 32'd0);
    check("sub_zf", {31'b0, zf}, 32'd1);

    // Signed SLT: -1 < 1
    load(5'd1, 32'hFFFF_FFFF);
    load(5'd2, 32'd1);
    runCmd(3'b100, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("slt_result", result, 32'd1);
    runCmd(3'b100, 5'd2, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("slt_rev", result, 32'd0);

    // Logic ops and write-back
    load(5'd5, 32'h0000_000A);
    load(5'd6, 32'h0000_0005);
    runCmd(3'b101, 5'd5, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("nor_result", result, 32'hFFFF_FFF0);
    runCmd(3'b000, 5'd5, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("and_zf", {31'b0, zf}, 32'd1);
    runCmd(3'b110, 5'd5, 5'd6, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    check("xor_result", result, 32'h0000_000F);
    runCmd(3'b111, 5'd4, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("wb_readback", result, expWb);

    // start and ld_en while busy are ignored
    load(5'd1, 32'd5);
    load(5'd2, 32'd3);
    base = doneCnt;
    @(negedge clk);
    op = 3'b010; ra1 = 5'd1; ra2 = 5'd2; mem_addr = 5'd7; mem_we = 1'b0; wb = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b111; ra1 = 5'd2;
    ld_en = 1'b1; ld_addr = 5'd1; ld_data = 32'h64;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; ld_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("busy_done", {31'b0, done}, 32'd1);
    check("busy_result", result, 32'd8);
    check("mem_readback", dout, 32'd8);
    repeat (5) @(negedge clk);
    check("busy_donecnt", doneCnt - base, 32'd1);
    runCmd(3'b111, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("busy_noload", result, 32'd5);

    // Load and start in the same IDLE cycle
    runCmd(3'b111, 5'd7, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234);
    check("ld_start", result, 32'h1234);

    // Wrapping ADD
    load(5'd1, 32'hFFFF_FFFF);
    load(5'd2, 32'd1);
    runCmd(3'b010, 5'd1, 5'd2, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("wrap_result", result, 32'd0);
    check("wrap_zf", {31'b0, zf}, 32'd1);
    check("wrap_dout", dout, 32'd8);

    // Reset during EXEC of a storing command
    @(negedge clk);
    op = 3'b001; ra1 = 5'd1; ra2 = 5'd2; mem_addr = 5'd9; mem_we = 1'b1; wb = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    base = doneCnt;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", doneCnt - base, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_zf", {31'b0, zf}, 32'd0);
    check("abort_dout", dout, 32'd0);
    runCmd(3'b111, 5'd1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("abort_reg", result, 32'd0);
    check("abort_mem9", dout, 32'd0);
    runCmd(3'b111, 5'd1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("abort_mem7", dout, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
